// File: rtl/sys_bus_pkg.sv
// Shared types and constants for the two-master native-bus arbiter.
// The state code doubles as the one-hot grant value.
package sys_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } arb_state_t;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;
  localparam int          TO_W          = 16;

endpackage

// File: rtl/mem_arbiter_if.sv
// picorv32-style native memory bus: valid/ready handshake plus addr/wdata/wstrb/rdata.
// master drives the request, slave answers with rdata/ready.
interface mem_arbiter_if #(
  parameter int AW = 32
);
  logic          valid;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic [31:0]   rdata;
  logic          ready;

  modport master (output valid, addr, wdata, wstrb, input rdata, ready);
  modport slave  (input valid, addr, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/arb_timeout.sv
// Slave-ready watchdog for the arbiter; present only when ARB_TIMEOUT_EN is defined.
// Counts owned cycles without s_ready and flags expiry on the TIMEOUT-th one.
`ifdef ARB_TIMEOUT_EN
module arb_timeout
  import sys_bus_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk24,
  input  logic reset,
  input  logic clear,
  input  logic busy,
  input  logic s_ready,
  output logic expire
);

  logic [TO_W-1:0] count_reg;

  always_ff @(posedge clk24) begin
    if (reset || clear) begin
      count_reg <= '0;
    end else if (busy && !s_ready) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // s_ready on the final cycle takes precedence over the timeout
  assign expire = busy && !s_ready && (count_reg == TO_W'(TIMEOUT - 1));

endmodule
`endif

// File: rtl/mem_arbiter.sv
// Two-master arbiter sharing one native-bus slave; round-robin or fixed priority.
// Optional slave-ready timeout enabled by defining ARB_TIMEOUT_EN.
module mem_arbiter
  import sys_bus_pkg::*;
#(
  parameter int AW        = 32,
  parameter int PRIO_MODE = 0,
  parameter int TIMEOUT   = 255
) (
  input  logic          clk24,
  input  logic          reset,
  mem_arbiter_if.slave  m0,
  mem_arbiter_if.slave  m1,
  mem_arbiter_if.master s,
  output logic [1:0]    grant,
  output logic          err
);

  arb_state_t    state_reg, state_next;
  logic          last_m1_reg, last_m1_next;
  logic          own0, own1, own_valid, expire;
  logic [31:0]   rsp_data;
  logic [AW-1:0] sel_addr;

  assign own0      = (state_reg == ST_OWN0);
  assign own1      = (state_reg == ST_OWN1);
  assign own_valid = (own0 && m0.valid) || (own1 && m1.valid);
  assign rsp_data  = expire ? TIMEOUT_RDATA : s.rdata;

  always_ff @(posedge clk24) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      last_m1_reg <= 1'b1;
    end else begin
      state_reg   <= state_next;
      last_m1_reg <= last_m1_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    last_m1_next = last_m1_reg;
    case (state_reg)
      ST_IDLE: begin
        if (m0.valid && m1.valid) begin
          state_next = ((PRIO_MODE == 1) || last_m1_reg) ? ST_OWN0 : ST_OWN1;
        end else if (m0.valid) begin
          state_next = ST_OWN0;
        end else if (m1.valid) begin
          state_next = ST_OWN1;
        end
      end
      ST_OWN0, ST_OWN1: begin
        // a master dropping valid aborts without touching the fairness pointer
        if (!own_valid) begin
          state_next = ST_IDLE;
        end else if (s.ready || expire) begin
          state_next   = ST_IDLE;
          last_m1_next = own1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    s.valid  = 1'b0;
    sel_addr = '0;
    s.wdata  = '0;
    s.wstrb  = '0;
    m0.rdata = '0;
    m0.ready = 1'b0;
    m1.rdata = '0;
    m1.ready = 1'b0;
    if (own0) begin
      s.valid  = m0.valid;
      sel_addr = m0.addr;
      s.wdata  = m0.wdata;
      s.wstrb  = m0.wstrb;
      m0.rdata = rsp_data;
      m0.ready = m0.valid && (s.ready || expire);
    end else if (own1) begin
      s.valid  = m1.valid;
      sel_addr = m1.addr;
      s.wdata  = m1.wdata;
      s.wstrb  = m1.wstrb;
      m1.rdata = rsp_data;
      m1.ready = m1.valid && (s.ready || expire);
    end
  end

  assign s.addr = sel_addr;
  assign grant  = state_reg;

`ifdef ARB_TIMEOUT_EN
  logic err_reg;

  arb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk24   (clk24),
    .reset   (reset),
    .clear   (state_reg == ST_IDLE),
    .busy    (own_valid),
    .s_ready (s.ready),
    .expire  (expire)
  );

  always_ff @(posedge clk24) begin
    if (reset) begin
      err_reg <= 1'b0;
    end else if (expire) begin
      err_reg <= 1'b1;
    end
  end

  assign err = err_reg;
`else
  logic unused_timeout;

  assign expire         = 1'b0;
  assign err            = 1'b0;
  assign unused_timeout = ^TO_W'(TIMEOUT);
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: DUT 0 round-robin, DUT 1 fixed priority, each with its own
// bench masters and a 1-wait slave; a spec-level model is compared every cycle.
module tb_mem_arbiter;
  import sys_bus_pkg::*;

  localparam int TO = 8;

  logic clk24 = 1'b0;
  logic reset = 1'b1;
  always #5 clk24 = ~clk24;

  int          m_pend  [2][2];
  logic [31:0] m_addr  [2][2];
  logic [31:0] m_wdata [2][2];
  logic [3:0]  m_wstrb [2][2];
  logic [31:0] m_rdata [2][2];
  logic        m_ready [2][2];
  logic        s_valid [2];
  logic [31:0] s_addr  [2];
  logic [31:0] s_wdata [2];
  logic [3:0]  s_wstrb [2];
  logic        s_ready [2];
  int          s_cnt   [2];
  logic [1:0]  grant   [2];
  logic        err     [2];
  logic [31:0] slv_rdata;
  logic        slv_hang;
  int          slv_wait;
  int          order   [2][$];

  int vectors     = 0;
  int miscompares = 0;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    mem_arbiter_if #(.AW(32)) m0_if ();
    mem_arbiter_if #(.AW(32)) m1_if ();
    mem_arbiter_if #(.AW(32)) s_if ();

    assign m0_if.valid     = (m_pend[gi][0] != 0);
    assign m0_if.addr      = m_addr[gi][0];
    assign m0_if.wdata     = m_wdata[gi][0];
    assign m0_if.wstrb     = m_wstrb[gi][0];
    assign m_rdata[gi][0]  = m0_if.rdata;
    assign m_ready[gi][0]  = m0_if.ready;
    assign m1_if.valid     = (m_pend[gi][1] != 0);
    assign m1_if.addr      = m_addr[gi][1];
    assign m1_if.wdata     = m_wdata[gi][1];
    assign m1_if.wstrb     = m_wstrb[gi][1];
    assign m_rdata[gi][1]  = m1_if.rdata;
    assign m_ready[gi][1]  = m1_if.ready;
    assign s_valid[gi]     = s_if.valid;
    assign s_addr[gi]      = s_if.addr;
    assign s_wdata[gi]     = s_if.wdata;
    assign s_wstrb[gi]     = s_if.wstrb;
    assign s_if.rdata      = slv_rdata;
    assign s_if.ready      = s_ready[gi];

    mem_arbiter #(.AW(32), .PRIO_MODE(gi), .TIMEOUT(TO)) dut (
      .clk24 (clk24),
      .reset (reset),
      .m0    (m0_if),
      .m1    (m1_if),
      .s     (s_if),
      .grant (grant[gi]),
      .err   (err[gi])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock: masters retire on ready, slave answers after slv_wait owned cycles.
  task automatic tick();
    logic rdy [2][2];
    logic sv  [2];
    @(negedge clk24);
    for (int d = 0; d < 2; d++) begin
      sv[d] = s_valid[d];
      for (int k = 0; k < 2; k++) begin
        rdy[d][k] = m_ready[d][k];
        if (rdy[d][k]) begin
          order[d].push_back(k);
          $display("txn dut%0d m%0d addr=%h wstrb=%b wdata=%h rdata=%h",
                   d, k, m_addr[d][k], m_wstrb[d][k], m_wdata[d][k], m_rdata[d][k]);
        end
      end
    end
    @(posedge clk24);
    #1;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 2; k++) begin
        if (rdy[d][k] && m_pend[d][k] > 0) m_pend[d][k]--;
      end
      if (s_ready[d]) begin
        s_ready[d] = 1'b0;
        s_cnt[d]   = 0;
      end else if (sv[d] && !slv_hang) begin
        if (s_cnt[d] + 1 >= slv_wait) begin
          s_ready[d] = 1'b1;
          s_cnt[d]   = 0;
        end else begin
          s_cnt[d]++;
        end
      end else begin
        s_cnt[d] = 0;
      end
    end
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((m_pend[0][0] + m_pend[0][1] + m_pend[1][0] + m_pend[1][1] != 0 ||
            grant[0] != 2'b00 || grant[1] != 2'b00) && n < budget) begin
      tick();
      n++;
    end
    vectors++;
    if (n >= budget) begin
      miscompares++;
      $display("FAIL wait_idle: got still busy after %0d cycles, expected idle", n);
    end
  endtask

  // Reference model: owner index (-1 idle), last served master, sticky error.
  initial begin : model
    int   owner [2];
    int   last  [2];
    int   tcnt  [2];
    logic err_m [2];
    logic v, to;
    for (int d = 0; d < 2; d++) begin
      owner[d] = -1;
      last[d]  = 1;
      tcnt[d]  = 0;
      err_m[d] = 1'b0;
    end
    @(posedge clk24);
    forever begin
      @(negedge clk24);
      for (int d = 0; d < 2; d++) begin
        v  = 1'b0;
        to = 1'b0;
        if (owner[d] >= 0) v = (m_pend[d][owner[d]] != 0);
`ifdef ARB_TIMEOUT_EN
        to = v && !s_ready[d] && (tcnt[d] == TO - 1);
`endif
        check($sformatf("d%0d_grant", d), 32'(grant[d]), (owner[d] < 0) ? 32'd0 : 32'(1 << owner[d]));
        check($sformatf("d%0d_s_valid", d), 32'(s_valid[d]), 32'(v));
        check($sformatf("d%0d_err", d), 32'(err[d]), 32'(err_m[d]));
        for (int k = 0; k < 2; k++) begin
          check($sformatf("d%0d_m%0d_ready", d, k), 32'(m_ready[d][k]),
                32'(owner[d] == k && v && (s_ready[d] || to)));
          check($sformatf("d%0d_m%0d_rdata", d, k), m_rdata[d][k],
                (owner[d] == k) ? (to ? TIMEOUT_RDATA : slv_rdata) : 32'd0);
        end
        if (owner[d] >= 0) begin
          check($sformatf("d%0d_s_addr", d), s_addr[d], m_addr[d][owner[d]]);
          check($sformatf("d%0d_s_wdata", d), s_wdata[d], m_wdata[d][owner[d]]);
          check($sformatf("d%0d_s_wstrb", d), 32'(s_wstrb[d]), 32'(m_wstrb[d][owner[d]]));
        end
        if (reset) begin
          owner[d] = -1;
          last[d]  = 1;
          tcnt[d]  = 0;
          err_m[d] = 1'b0;
        end else if (owner[d] < 0) begin
          tcnt[d] = 0;
          if (m_pend[d][0] != 0 && m_pend[d][1] != 0) owner[d] = (d == 1) ? 0 : 1 - last[d];
          else if (m_pend[d][0] != 0) owner[d] = 0;
          else if (m_pend[d][1] != 0) owner[d] = 1;
        end else if (!v) begin
          owner[d] = -1;
        end else if (s_ready[d] || to) begin
          if (to) err_m[d] = 1'b1;
          last[d]  = owner[d];
          owner[d] = -1;
        end else begin
          tcnt[d]++;
        end
      end
    end
  end

  initial begin : stimulus
    int exp_rr [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
    int exp_fp [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    for (int d = 0; d < 2; d++) begin
      s_ready[d] = 1'b0;
      s_cnt[d]   = 0;
      for (int k = 0; k < 2; k++) begin
        m_pend[d][k]  = 0;
        m_addr[d][k]  = 32'h0;
        m_wdata[d][k] = 32'h0;
        m_wstrb[d][k] = 4'h0;
      end
    end
    slv_rdata = 32'h0;
    slv_hang  = 1'b0;
    slv_wait  = 1;
    tick();
    tick();
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d_reset_grant", d), 32'(grant[d]), 32'd0);
      check($sformatf("d%0d_reset_s_valid", d), 32'(s_valid[d]), 32'd0);
      check($sformatf("d%0d_reset_err", d), 32'(err[d]), 32'd0);
    end

    // Single m0 read with a 1-wait slave: 3 cycles per access
    slv_rdata = 32'h1234_5678;
    for (int d = 0; d < 2; d++) begin
      m_addr[d][0] = 32'h1000_0010;
      m_pend[d][0] = 1;
    end
    tick();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d_rd_grant", d), 32'(grant[d]), 32'h1);
      check($sformatf("d%0d_rd_addr", d), s_addr[d], 32'h1000_0010);
    end
    tick();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d_rd_ready", d), 32'(m_ready[d][0]), 32'h1);
      check($sformatf("d%0d_rd_rdata", d), m_rdata[d][0], 32'h1234_5678);
      check($sformatf("d%0d_rd_m1_ready", d), 32'(m_ready[d][1]), 32'h0);
    end
    tick();
    for (int d = 0; d < 2; d++) check($sformatf("d%0d_rd_done_grant", d), 32'(grant[d]), 32'h0);

    // Both masters hold valid for 4 transactions each
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      order[d].delete();
      m_addr[d][1] = 32'h1000_0040;
      m_pend[d][0] = 4;
      m_pend[d][1] = 4;
    end
    slv_rdata = 32'h0BAD_F00D;
    wait_idle(100);
    check("rr_count", 32'(order[0].size()), 32'd8);
    check("fp_count", 32'(order[1].size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < order[0].size()) check($sformatf("rr_order%0d", i), 32'(order[0][i]), 32'(exp_rr[i]));
      if (i < order[1].size()) check($sformatf("fp_order%0d", i), 32'(order[1][i]), 32'(exp_fp[i]));
    end

    // m1 partial write
    for (int d = 0; d < 2; d++) begin
      m_addr[d][1]  = 32'h1000_0020;
      m_wdata[d][1] = 32'hA5A5_A5A5;
      m_wstrb[d][1] = 4'b0011;
      m_pend[d][1]  = 1;
    end
    tick();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d_wr_grant", d), 32'(grant[d]), 32'h2);
      check($sformatf("d%0d_wr_wdata", d), s_wdata[d], 32'hA5A5_A5A5);
      check($sformatf("d%0d_wr_wstrb", d), 32'(s_wstrb[d]), 32'h3);
    end
    tick();
    for (int d = 0; d < 2; d++) check($sformatf("d%0d_wr_ready", d), 32'(m_ready[d][1]), 32'h1);
    tick();
    for (int d = 0; d < 2; d++) check($sformatf("d%0d_wr_s_valid_after", d), 32'(s_valid[d]), 32'h0);

    // Reset while owning with the slave stalled
    slv_hang = 1'b1;
    for (int d = 0; d < 2; d++) m_pend[d][0] = 1;
    tick();
    tick();
    reset = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d_rst_grant", d), 32'(grant[d]), 32'h0);
      check($sformatf("d%0d_rst_s_valid", d), 32'(s_valid[d]), 32'h0);
      check($sformatf("d%0d_rst_ready", d), 32'(m_ready[d][0]), 32'h0);
    end
    reset = 1'b0;
    tick();
    for (int d = 0; d < 2; d++) check($sformatf("d%0d_rst_regrant", d), 32'(grant[d]), 32'h1);
    slv_hang = 1'b0;
    wait_idle(20);

    // m0 aborts mid-ownership; pending m1 is granted next
    slv_hang = 1'b1;
    for (int d = 0; d < 2; d++) m_pend[d][0] = 1;
    tick();
    for (int d = 0; d < 2; d++) begin
      order[d].delete();
      m_pend[d][0] = 0;
      m_pend[d][1] = 1;
    end
    tick();
    for (int d = 0; d < 2; d++) check($sformatf("d%0d_abort_grant", d), 32'(grant[d]), 32'h0);
    tick();
    for (int d = 0; d < 2; d++) check($sformatf("d%0d_abort_next", d), 32'(grant[d]), 32'h2);
    slv_hang = 1'b0;
    wait_idle(20);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d_abort_txns", d), 32'(order[d].size()), 32'd1);
      if (order[d].size() == 1) check($sformatf("d%0d_abort_who", d), 32'(order[d][0]), 32'd1);
    end

`ifdef ARB_TIMEOUT_EN
    slv_hang = 1'b1;
    for (int d = 0; d < 2; d++) m_pend[d][0] = 1;
    for (int i = 0; i < TO; i++) tick();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d_to_ready", d), 32'(m_ready[d][0]), 32'h1);
      check($sformatf("d%0d_to_rdata", d), m_rdata[d][0], 32'hDEAD_BEEF);
    end
    tick();
    tick();
    for (int d = 0; d < 2; d++) check($sformatf("d%0d_to_err", d), 32'(err[d]), 32'h1);
    slv_hang = 1'b0;
    wait_idle(20);
`endif

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #200000;
    miscompares++;
    $display("FAIL watchdog: got no completion by 200000, expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-master arbiter for the picorv32-style native memory bus (valid/ready/addr/wdata/wstrb/rdata). Shares one slave port, e.g. the SPRAM window at 0x1000_0000, between the CPU (m0) and a second bus master such as a DMA or video fetcher (m1). Sits between the masters and the system address decode. Each granted transaction is held until the slave asserts ready. Arbitration is round-robin, or fixed priority by parameter.

Parameters:
AW, 32, address width of master and slave ports
PRIO_MODE, 0, 0 = round-robin; 1 = fixed priority (m0 always wins ties)
TIMEOUT, 255, slave-ready timeout in cycles; used only with ARB_TIMEOUT_EN; range 1..65535

Ports:
clk24  in  1  system clock
reset  in  1  synchronous active-high reset
m0_valid  in  1  master 0 request
m0_addr  in  AW  master 0 address
m0_wdata  in  32  master 0 write data
m0_wstrb  in  4  master 0 byte strobes; 0 = read
m0_rdata  out  32  master 0 read data
m0_ready  out  1  master 0 completion pulse
m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_rdata, m1_ready  as m0, for master 1
s_valid  out  1  slave request
s_addr  out  AW  slave address
s_wdata  out  32  slave write data
s_wstrb  out  4  slave byte strobes
s_rdata  in  32  slave read data
s_ready  in  1  slave completion
grant  out  2  one-hot current owner; 00 = idle
err  out  1  sticky timeout flag; tied 0 without ARB_TIMEOUT_EN

Behaviour:
- Reset (sync, at clk24 edge): state IDLE, grant=00, s_valid=0, m0_ready=m1_ready=0, last-served pointer=m1 (so m0 wins the first tie), err=0.
- States: IDLE, OWN0, OWN1.
- IDLE: sample m0_valid/m1_valid.
  - Exactly one requesting: go to OWN of that master.
  - Both requesting, PRIO_MODE=0: grant the master not served last. PRIO_MODE=1: grant m0.
  - Neither requesting: stay in IDLE.
  - Arbitration costs exactly 1 cycle. s_valid=0 in IDLE.
- OWNn: s_valid = mn_valid. s_addr/s_wdata/s_wstrb are combinational from master n. mn_rdata = s_rdata combinationally. The other master's rdata=0 and ready=0.
- OWNn with s_ready=1: mn_ready=1 in the same cycle (combinational). Next state IDLE; last pointer := n.
- OWNn with mn_valid=0 (master protocol violation / abort): return to IDLE, no ready pulse, pointer unchanged.
- In IDLE, m*_ready is always 0 and s_ready is ignored.
- Throughput: one transaction per (1 + slave latency) cycles. With mem_rdy-style 1-wait slaves, 3 cycles per access.
- wstrb is passed through unmodified; the arbiter never splits or merges accesses.
- grant is registered and equals the one-hot state encoding.

Optional Feature:
ARB_TIMEOUT_EN:
- Defined: a 16-bit counter clears on entry to OWNn and increments each OWNn cycle without s_ready.
  - When count == TIMEOUT-1 and s_ready is still 0: force mn_ready=1 and mn_rdata=32'hDEAD_BEEF. Set err=1 (sticky until reset). Return to IDLE.
  - If s_ready and timeout coincide, s_ready wins: normal data, err unchanged.
- Undefined: no counter; err constant 0; a hung slave hangs the owner indefinitely.

Decomposition:
- Package sys_bus_pkg:
  - state encoding ST_IDLE=2'b00, ST_OWN0=2'b01, ST_OWN1=2'b10, which doubles as the grant code
  - TIMEOUT_RDATA=32'hDEAD_BEEF
  - counter width constant TO_W=16
- Sub-module arb_timeout: counter, clear, compare, and expire output. Instantiated only under ARB_TIMEOUT_EN.

Test Plan:
- m0 reads 0x1000_0010, slave returns 0x1234_5678 with 1 wait cycle -> grant=01 one cycle after valid; m0_ready pulses 1 cycle with m0_rdata=0x1234_5678; m1_ready stays 0.
- m0 and m1 both hold valid for 4 transactions, PRIO_MODE=0 -> grant order 01,10,01,10. With PRIO_MODE=1 -> m0 served while it requests; m1 only when m0_valid=0.
- m1 write 0xA5A5_A5A5, wstrb=4'b0011 -> s_wdata/s_wstrb match exactly during OWN1; s_valid deasserts the cycle after s_ready.
- Assert reset while in OWN0 with s_ready=0 -> next edge: grant=00, s_valid=0, no m0_ready pulse; next request arbitrated normally.
- m0 drops valid mid-OWN0 -> return to IDLE, no ready; pending m1 granted on the following cycle.
- ARB_TIMEOUT_EN with TIMEOUT=8 and s_ready held low -> m0_ready at the 8th OWN0 cycle with rdata 0xDEAD_BEEF; err=1 and stays 1 until reset.
